uart_bus_ctrl: RTL and testbench

Memory-mapped controller that sequences the byte-level UART receiver and transmitter cores for the MIPS CPU data bus. It captures each RX_STATUS strobe and its RX_DATA byte into a small RX FIFO. It holds one pending TX byte and starts the transmitter with a single-cycle TX_EN handshake. It exposes data, control and status registers and generates a level interrupt to the CPU.

---
 rtl/uart_bus_ctrl_pkg.sv | 29 ++
 rtl/uart_rx_fifo.sv | 52 +++++
 rtl/uart_bus_ctrl.sv | 163 ++++++++++++++++
 tb/tb_uart_bus_ctrl.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_bus_ctrl_pkg.sv
// Shared constants for the UART bus controller: register map, TX FSM encoding,
// CTRL/STAT bit positions and the transmitter busy timeout.
package uart_bus_ctrl_pkg;

   localparam logic [1:0] ADDR_TXD  = 2'd0;
   localparam logic [1:0] ADDR_RXD  = 2'd1;
   localparam logic [1:0] ADDR_CTRL = 2'd2;
   localparam logic [1:0] ADDR_STAT = 2'd3;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      START     = 2'd1,
      WAIT_BUSY = 2'd2,
      WAIT_DONE = 2'd3
   } tx_state_t;

   localparam int CTRL_RX_IE    = 0;
   localparam int CTRL_TX_IE    = 1;
   localparam int CTRL_LOOPBACK = 2;

   localparam int STAT_RX_NONEMPTY = 0;
   localparam int STAT_TX_READY    = 1;
   localparam int STAT_OVERFLOW    = 2;
   localparam int STAT_RX_FULL     = 3;
   localparam int STAT_COUNT_LSB   = 8;

   localparam logic [3:0] TX_TIMEOUT = 4'd15;

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous byte FIFO for received UART data; a pop in the same cycle frees
// a slot so a push into a full FIFO is still accepted.
module uart_rx_fifo #(
   parameter int RX_DEPTH = 4,
   parameter int RX_AW    = 2
) (
   input  logic             sysclk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [7:0]       din,
   output logic [7:0]       dout,
   output logic             full,
   output logic             empty,
   output logic [RX_AW:0]   count
);

   localparam logic [RX_AW:0] FULL_COUNT = (RX_AW+1)'(RX_DEPTH);

   logic [7:0]       mem [RX_DEPTH];
   logic [RX_AW-1:0] wr_ptr;
   logic [RX_AW-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == FULL_COUNT);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge sysclk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   always_ff @(posedge sysclk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/uart_bus_ctrl.sv
// Memory-mapped UART controller: RX FIFO, single pending TX byte, CTRL/STAT
// registers and level irq. Define UART_LOOPBACK_EN to route TX bytes into the RX FIFO.
module uart_bus_ctrl
   import uart_bus_ctrl_pkg::*;
#(
   parameter int RX_DEPTH = 4,
   parameter int RX_AW    = 2
) (
   input  logic        sysclk,
   input  logic        reset,
   input  logic [1:0]  addr,
   input  logic        rd,
   input  logic        wr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        irq,
   input  logic        RX_STATUS,
   input  logic [7:0]  RX_DATA,
   output logic        TX_EN,
   output logic [7:0]  TX_DATA,
   input  logic        TX_STATUS
);

   tx_state_t        state, state_next;
   logic [3:0]       timer;
   logic             tx_pend, tx_done;
   logic [7:0]       tx_data_q;
   logic             overflow;
   logic             rx_ie, tx_ie, loopback;
   logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [7:0]       fifo_din, fifo_dout;
   logic [RX_AW:0]   fifo_count;
   logic [31:0]      stat_word;
   logic             unused_wdata;

   assign unused_wdata = ^wdata[31:3];
   assign TX_DATA      = tx_data_q;
   assign fifo_pop     = rd && (addr == ADDR_RXD) && !fifo_empty;

`ifdef UART_LOOPBACK_EN
   assign fifo_push = loopback ? (state == START) : RX_STATUS;
   assign fifo_din  = loopback ? tx_data_q : RX_DATA;

   always_ff @(posedge sysclk or negedge reset) begin
      if (!reset)                          loopback <= 1'b0;
      else if (wr && addr == ADDR_CTRL)    loopback <= wdata[CTRL_LOOPBACK];
   end
`else
   assign fifo_push = RX_STATUS;
   assign fifo_din  = RX_DATA;
   assign loopback  = 1'b0;
`endif

   uart_rx_fifo #(.RX_DEPTH(RX_DEPTH), .RX_AW(RX_AW)) u_rx_fifo (
      .sysclk (sysclk),
      .reset  (reset),
      .push   (fifo_push),
      .pop    (fifo_pop),
      .din    (fifo_din),
      .dout   (fifo_dout),
      .full   (fifo_full),
      .empty  (fifo_empty),
      .count  (fifo_count)
   );

   always_comb begin
      state_next = state;
      TX_EN      = 1'b0;
      tx_done    = 1'b0;
      case (state)
         IDLE:      if (tx_pend && TX_STATUS) state_next = START;
         START: begin
            if (loopback) begin
               tx_done    = 1'b1;
               state_next = IDLE;
            end else begin
               TX_EN      = 1'b1;
               state_next = WAIT_BUSY;
            end
         end
         WAIT_BUSY: begin
            if (!TX_STATUS) begin
               state_next = WAIT_DONE;
            end else if (timer == '0) begin
               tx_done    = 1'b1;
               state_next = IDLE;
            end
         end
         WAIT_DONE: begin
            if (TX_STATUS) begin
               tx_done    = 1'b1;
               state_next = IDLE;
            end
         end
         default:   state_next = IDLE;
      endcase
   end

   // Timer counts the cycles spent in WAIT_BUSY; terminal count means the
   // transmitter never reported busy and the byte is assumed sent.
   always_ff @(posedge sysclk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         timer <= '0;
      end else begin
         state <= state_next;
         if (state == START)                         timer <= TX_TIMEOUT - 4'd1;
         else if (state == WAIT_BUSY && timer != '0) timer <= timer - 4'd1;
      end
   end

   always_ff @(posedge sysclk or negedge reset) begin
      if (!reset) begin
         tx_pend   <= 1'b0;
         tx_data_q <= '0;
         rx_ie     <= 1'b0;
         tx_ie     <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         if (wr && addr == ADDR_TXD && !tx_pend) begin
            tx_data_q <= wdata[7:0];
            tx_pend   <= 1'b1;
         end else if (tx_done) begin
            tx_pend   <= 1'b0;
         end
         if (wr && addr == ADDR_CTRL) begin
            rx_ie <= wdata[CTRL_RX_IE];
            tx_ie <= wdata[CTRL_TX_IE];
         end
         if (fifo_push && fifo_full && !fifo_pop)
            overflow <= 1'b1;
         else if (wr && addr == ADDR_STAT && wdata[STAT_OVERFLOW])
            overflow <= 1'b0;
      end
   end

   always_comb begin
      stat_word                                  = '0;
      stat_word[STAT_RX_NONEMPTY]                = !fifo_empty;
      stat_word[STAT_TX_READY]                   = !tx_pend;
      stat_word[STAT_OVERFLOW]                   = overflow;
      stat_word[STAT_RX_FULL]                    = fifo_full;
      stat_word[STAT_COUNT_LSB +: RX_AW+1]       = fifo_count;
   end

   always_ff @(posedge sysclk or negedge reset) begin
      if (!reset) begin
         rdata <= '0;
         irq   <= 1'b0;
      end else begin
         irq <= (rx_ie && !fifo_empty) || (tx_ie && !tx_pend);
         if (rd) begin
            case (addr)
               ADDR_TXD:  rdata <= {24'b0, tx_data_q};
               ADDR_RXD:  rdata <= fifo_empty ? 32'b0 : {24'b0, fifo_dout};
               ADDR_CTRL: rdata <= {29'b0, loopback, tx_ie, rx_ie};
               default:   rdata <= stat_word;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_uart_bus_ctrl.sv
// Directed bench for uart_bus_ctrl with an RX byte scoreboard and a small
// STAT model; loopback steps run when UART_LOOPBACK_EN is defined.
module tb_uart_bus_ctrl;

   localparam int DEPTH = 4;

   logic        sysclk = 1'b0;
   logic        reset  = 1'b0;
   logic [1:0]  addr   = '0;
   logic        rd     = 1'b0;
   logic        wr     = 1'b0;
   logic [31:0] wdata  = '0;
   logic [31:0] rdata;
   logic        irq;
   logic        RX_STATUS = 1'b0;
   logic [7:0]  RX_DATA   = '0;
   logic        TX_EN;
   logic [7:0]  TX_DATA;
   logic        TX_STATUS = 1'b1;

   int checks = 0;
   int errors = 0;
   int tx_en_count = 0;

   logic [7:0] exp_q[$];
   int         model_count = 0;
   logic       model_ovf   = 1'b0;

   uart_bus_ctrl #(.RX_DEPTH(DEPTH), .RX_AW(2)) dut (
      .sysclk    (sysclk),
      .reset     (reset),
      .addr      (addr),
      .rd        (rd),
      .wr        (wr),
      .wdata     (wdata),
      .rdata     (rdata),
      .irq       (irq),
      .RX_STATUS (RX_STATUS),
      .RX_DATA   (RX_DATA),
      .TX_EN     (TX_EN),
      .TX_DATA   (TX_DATA),
      .TX_STATUS (TX_STATUS)
   );

   always #5 sysclk = ~sysclk;

   always @(negedge sysclk) if (TX_EN === 1'b1) tx_en_count++;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] stat_model(input logic tx_ready);
      logic [31:0] s;
      s       = '0;
      s[0]    = (model_count != 0);
      s[1]    = tx_ready;
      s[2]    = model_ovf;
      s[3]    = (model_count == DEPTH);
      s[10:8] = 3'(model_count);
      return s;
   endfunction

   task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
      @(negedge sysclk);
      addr = a; wdata = d; wr = 1'b1;
      @(negedge sysclk);
      wr = 1'b0;
   endtask

   task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
      @(negedge sysclk);
      addr = a; rd = 1'b1;
      @(negedge sysclk);
      rd = 1'b0;
      d  = rdata;
   endtask

   task automatic model_push(input logic [7:0] b);
      if (model_count < DEPTH) begin
         exp_q.push_back(b);
         model_count++;
      end else begin
         model_ovf = 1'b1;
      end
   endtask

   task automatic rx_strobe(input logic [7:0] b);
      @(negedge sysclk);
      RX_STATUS = 1'b1; RX_DATA = b;
      model_push(b);
      @(negedge sysclk);
      RX_STATUS = 1'b0;
   endtask

   task automatic read_rx(input string tag);
      logic [31:0] d;
      logic [31:0] e;
      bus_read(2'd1, d);
      if (exp_q.size() > 0) begin
         e = {24'b0, exp_q.pop_front()};
         model_count--;
      end else begin
         e = '0;
      end
      check(tag, d, e);
   endtask

   task automatic read_stat(input string tag, input logic tx_ready);
      logic [31:0] d;
      bus_read(2'd3, d);
      check(tag, d, stat_model(tx_ready));
   endtask

   task automatic wait_tx_en(input string tag);
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         @(negedge sysclk);
         if (TX_EN === 1'b1) seen = 1'b1;
      end
      check(tag, {31'b0, seen}, 32'd1);
   endtask

   initial begin
      logic [31:0] d;

      // reset
      repeat (3) @(negedge sysclk);
      check("rst_irq", {31'b0, irq}, 32'd0);
      check("rst_tx_en", {31'b0, TX_EN}, 32'd0);
      check("rst_tx_data", {24'b0, TX_DATA}, 32'd0);
      check("rst_rdata", rdata, 32'd0);
      reset = 1'b1;
      bus_read(2'd3, d);
      check("rst_stat", d, 32'h2);

      // two RX bytes with rx_ie
      bus_write(2'd2, 32'h1);
      bus_read(2'd2, d);
      check("ctrl_rx_ie", d, 32'h1);
      rx_strobe(8'h41);
      check("irq_not_yet", {31'b0, irq}, 32'd0);
      @(negedge sysclk);
      check("irq_rise", {31'b0, irq}, 32'd1);
      rx_strobe(8'h42);
      read_stat("stat_cnt2", 1'b1);
      read_rx("rx_0x41");
      read_rx("rx_0x42");
      @(negedge sysclk);
      check("irq_fall", {31'b0, irq}, 32'd0);
      bus_write(2'd2, 32'h0);

      // overflow
      for (int i = 0; i < 5; i++) rx_strobe(8'h10 + 8'(i));
      read_stat("stat_ovf_full", 1'b1);
      for (int i = 0; i < DEPTH; i++) read_rx("rx_ovf_seq");
      read_rx("rx_empty_zero");
      bus_write(2'd3, 32'h4);
      model_ovf = 1'b0;
      read_stat("stat_ovf_clr", 1'b1);

      // tx_ie irq
      bus_write(2'd2, 32'h2);
      @(negedge sysclk);
      check("irq_tx_ready", {31'b0, irq}, 32'd1);
      bus_write(2'd2, 32'h0);

      // TX with busy transmitter
      bus_write(2'd0, 32'h55);
      wait_tx_en("tx_en_seen");
      check("tx_data_55", {24'b0, TX_DATA}, 32'h55);
      @(negedge sysclk);
      check("tx_en_one_cycle", {31'b0, TX_EN}, 32'd0);
      TX_STATUS = 1'b0;
      bus_write(2'd0, 32'hAA);
      read_stat("stat_tx_busy", 1'b0);
      bus_read(2'd0, d);
      check("txd_hold_55", d, 32'h55);
      repeat (155) @(negedge sysclk);
      check("tx_busy_pend", {31'b0, dut.tx_pend}, 32'd1);
      TX_STATUS = 1'b1;
      repeat (3) @(negedge sysclk);
      read_stat("stat_tx_done", 1'b1);
      bus_read(2'd0, d);
      check("txd_after", d, 32'h55);
      check("tx_en_count1", tx_en_count, 32'd1);

      // TX timeout (transmitter never reports busy)
      bus_write(2'd0, 32'h66);
      wait_tx_en("tx_en_seen2");
      check("tx_data_66", {24'b0, TX_DATA}, 32'h66);
      read_stat("stat_timeout_pend", 1'b0);
      repeat (20) @(negedge sysclk);
      read_stat("stat_timeout_done", 1'b1);
      check("tx_en_count2", tx_en_count, 32'd2);

      // full FIFO with simultaneous push and pop
      for (int i = 0; i < DEPTH; i++) rx_strobe(8'h20 + 8'(i));
      @(negedge sysclk);
      RX_STATUS = 1'b1; RX_DATA = 8'h99; addr = 2'd1; rd = 1'b1;
      @(negedge sysclk);
      RX_STATUS = 1'b0; rd = 1'b0;
      check("simul_pop", rdata, {24'b0, exp_q.pop_front()});
      model_count--;
      model_push(8'h99);
      read_stat("stat_simul", 1'b1);
      for (int i = 0; i < DEPTH; i++) read_rx("rx_simul_seq");

`ifdef UART_LOOPBACK_EN
      bus_write(2'd2, 32'h4);
      bus_read(2'd2, d);
      check("ctrl_loopback", d, 32'h4);
      bus_write(2'd0, 32'h3C);
      model_push(8'h3C);
      repeat (5) @(negedge sysclk);
      check("loop_no_tx_en", tx_en_count, 32'd2);
      read_stat("stat_loop", 1'b1);
      read_rx("rx_loop_3c");
`else
      bus_write(2'd2, 32'h7);
      bus_read(2'd2, d);
      check("ctrl_no_loopback", d, 32'h3);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
